// File: rtl/shift_pkg.sv
// Shared definitions for the shifter front end: op encodings and requester IDs.
package shift_pkg;

    // {right, arith}; LUI reuses the left-shift path with a fixed amount of 16
    typedef enum logic [1:0] {
        SH_SLL = 2'b00,
        SH_LUI = 2'b01,
        SH_SRL = 2'b10,
        SH_SRA = 2'b11
    } sh_op_e;

    localparam logic REQ_EX = 1'b0;
    localparam logic REQ_MD = 1'b1;

endpackage

// File: rtl/shift_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; last_grant only moves on an accepted transfer.
module rr_arb2
    import shift_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    input  logic       xfer_i,
    output logic [1:0] grant_o
);

    logic last_q, last_d;

    always_comb begin
        grant_o = 2'b00;
        unique case (req_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11:   grant_o = (last_q == REQ_MD) ? 2'b01 : 2'b10;
            default: grant_o = 2'b00;
        endcase
    end

    always_comb begin
        last_d = last_q;
        if (xfer_i) begin
            last_d = grant_o[1] ? REQ_MD : REQ_EX;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_q <= REQ_MD;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/shifter.sv
// Shared combinational barrel shifter; {right, arith} = 2'b01 selects LUI.
module shifter (
    input  logic [31:0] data_i,
    input  logic [31:0] sa_i,
    input  logic        right_i,
    input  logic        arith_i,
    output logic [31:0] result_o
);

    always_comb begin
        result_o = data_i;
        unique case ({right_i, arith_i})
            2'b00: result_o = data_i << sa_i;
            2'b01: result_o = data_i << 16;
            2'b10: result_o = data_i >> sa_i;
            2'b11: result_o = $signed(data_i) >>> sa_i;
        endcase
    end

endmodule

// File: rtl/shift_arbiter.sv
// Two-requester, two-stage pipelined front end for the shared barrel shifter.
module shift_arbiter
    import shift_pkg::*;
#(
    parameter int unsigned TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [31:0]      req_data0,
    input  logic [31:0]      req_data1,
    input  logic [4:0]       req_sa0,
    input  logic [4:0]       req_sa1,
    input  logic [1:0]       req_op0,
    input  logic [1:0]       req_op1,
    input  logic [TAG_W-1:0] req_tag0,
    input  logic [TAG_W-1:0] req_tag1,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [31:0]      resp_data,
    output logic             resp_id,
    output logic [TAG_W-1:0] resp_tag
);

    logic             s1_valid_q, s1_valid_d;
    logic [31:0]      s1_data_q,  s1_data_d;
    logic [4:0]       s1_sa_q,    s1_sa_d;
    sh_op_e           s1_op_q,    s1_op_d;
    logic             s1_id_q,    s1_id_d;
    logic [TAG_W-1:0] s1_tag_q,   s1_tag_d;

    logic             s2_valid_q, s2_valid_d;
    logic [31:0]      s2_data_q,  s2_data_d;
    logic             s2_id_q,    s2_id_d;
    logic [TAG_W-1:0] s2_tag_q,   s2_tag_d;

    logic [1:0]       grant;
    logic             s1_load, s2_load, xfer;
    logic [31:0]      shift_res;

    assign s2_load = s1_valid_q && (!s2_valid_q || resp_ready);
    assign s1_load = !s1_valid_q || s2_load;

    // Gated by rst so nothing is offered while the pipeline is held in reset
    assign req_ready = (rst || !s1_load) ? 2'b00 : grant;
    assign xfer      = |(req_valid & req_ready);

    rr_arb2 u_arb (
        .clk_i   (clk),
        .rst_i   (rst),
        .req_i   (req_valid),
        .xfer_i  (xfer),
        .grant_o (grant)
    );

    shifter u_shifter (
        .data_i   (s1_data_q),
        .sa_i     ({27'b0, s1_sa_q}),
        .right_i  (s1_op_q[1]),
        .arith_i  (s1_op_q[0]),
        .result_o (shift_res)
    );

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_data_d  = s1_data_q;
        s1_sa_d    = s1_sa_q;
        s1_op_d    = s1_op_q;
        s1_id_d    = s1_id_q;
        s1_tag_d   = s1_tag_q;
        if (xfer) begin
            s1_valid_d = 1'b1;
            s1_data_d  = grant[1] ? req_data1 : req_data0;
            s1_sa_d    = grant[1] ? req_sa1   : req_sa0;
            s1_op_d    = sh_op_e'(grant[1] ? req_op1 : req_op0);
            s1_id_d    = grant[1] ? REQ_MD    : REQ_EX;
            s1_tag_d   = grant[1] ? req_tag1  : req_tag0;
        end else if (s2_load) begin
            s1_valid_d = 1'b0;
        end
    end

    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        s2_id_d    = s2_id_q;
        s2_tag_d   = s2_tag_q;
        if (s2_load) begin
            s2_valid_d = 1'b1;
            s2_data_d  = shift_res;
            s2_id_d    = s1_id_q;
            s2_tag_d   = s1_tag_q;
        end else if (resp_ready) begin
            s2_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_sa_q    <= '0;
            s1_op_q    <= SH_SLL;
            s1_id_q    <= REQ_EX;
            s1_tag_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_id_q    <= REQ_EX;
            s2_tag_q   <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            s1_sa_q    <= s1_sa_d;
            s1_op_q    <= s1_op_d;
            s1_id_q    <= s1_id_d;
            s1_tag_q   <= s1_tag_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            s2_id_q    <= s2_id_d;
            s2_tag_q   <= s2_tag_d;
        end
    end

    assign resp_valid = s2_valid_q;
    assign resp_data  = s2_data_q;
    assign resp_id    = s2_id_q;
    assign resp_tag   = s2_tag_q;

endmodule
